// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state
// encoding, opcode/funct values, ALU operation codes and ALUOp encoding.
package mips_pkg;

    // Controller states. Four encodings (12..15) are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;

    // ALU operation codes seen by the datapath ALU
    localparam logic [2:0] ALUCTL_AND  = 3'b000;
    localparam logic [2:0] ALUCTL_OR   = 3'b001;
    localparam logic [2:0] ALUCTL_ADD  = 3'b010;
    localparam logic [2:0] ALUCTL_SRAV = 3'b101;
    localparam logic [2:0] ALUCTL_SUB  = 3'b110;
    localparam logic [2:0] ALUCTL_SLT  = 3'b111;

    // Coarse ALU request from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    // Map an R-type funct field to its ALU operation; unknown functs add.
    function automatic logic [2:0] funct_to_aluctl(input logic [5:0] funct);
        logic [2:0] ctl;
        case (funct)
            FUNCT_ADD:  ctl = ALUCTL_ADD;
            FUNCT_SUB:  ctl = ALUCTL_SUB;
            FUNCT_AND:  ctl = ALUCTL_AND;
            FUNCT_OR:   ctl = ALUCTL_OR;
            FUNCT_SLT:  ctl = ALUCTL_SLT;
            FUNCT_SRAV: ctl = ALUCTL_SRAV;
            default:    ctl = ALUCTL_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. The master side is the controller: it
// reads the instruction fields and ALU zero flag and drives every strobe.
interface multicycle_control_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic [2:0] AluControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       PCEn;

    modport master (
        input  Op, Funct, Zero,
        output AluControl, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite,
               MemWrite, RegWrite, RegDst, MemtoReg, PCEn
    );

    modport slave (
        output Op, Funct, Zero,
        input  AluControl, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite,
               MemWrite, RegWrite, RegDst, MemtoReg, PCEn
    );
endinterface

// File: rtl/alu_decoder.sv
// ALU decoder: turns the FSM's coarse ALUOp request plus the R-type funct
// field into the 3-bit operation code for the datapath ALU.
module alu_decoder
    import mips_pkg::*;
(
    input  aluop_e     alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    // Select add/sub directly, or defer to the funct field for R-type.
    always_comb begin
        alu_control_o = ALUCTL_ADD;
        case (alu_op_i)
            ALUOP_ADD:   alu_control_o = ALUCTL_ADD;
            ALUOP_SUB:   alu_control_o = ALUCTL_SUB;
            ALUOP_FUNCT: alu_control_o = funct_to_aluctl(funct_i);
            default:     alu_control_o = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main controller for the 32-bit multicycle MIPS datapath. A Moore FSM
// sequences each instruction; outputs depend only on the state, except
// PCEn (also Zero) and AluControl (also Funct). While reset is high the
// write strobes are held low and the selects show their FETCH values.
module multicycle_control
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master ctrl
);

    state_e     state_q;
    state_e     state_d;

    logic       ir_write_s;
    logic       pc_write_s;
    logic       branch_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic       iord_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] pc_src_s;
    aluop_e     alu_op_s;
    logic [2:0] alu_control_s;

    // State register; reset forces FETCH without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (ctrl.Op)
                    OP_LW:    state_d = S_MEMADR;
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXECUTE;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_ADDI:  state_d = S_ADDIEXEC;
                    OP_J:     state_d = S_JUMP;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (ctrl.Op == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD:    state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state strobe and select decode; anything not named stays 0 / add.
    always_comb begin
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        iord_s       = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_src_s     = 2'b00;
        alu_op_s     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b_s = 2'b01;
                ir_write_s  = 1'b1;
                pc_write_s  = 1'b1;
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
            end
            S_MEMADR, S_ADDIEXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEMRD: begin
                iord_s = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg_s = 1'b1;
                reg_write_s  = 1'b1;
            end
            S_MEMWR: begin
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst_s   = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = ALUOP_SUB;
                pc_src_s    = 2'b01;
                branch_s    = 1'b1;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
            end
            S_JUMP: begin
                pc_src_s   = 2'b10;
                pc_write_s = 1'b1;
            end
            default: begin
                alu_op_s = ALUOP_ADD;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op_s),
        .funct_i       (ctrl.Funct),
        .alu_control_o (alu_control_s)
    );

    // Selects pass straight through; write strobes are blocked during reset
    // so an abandoned instruction cannot disturb architectural state.
    assign ctrl.AluControl = alu_control_s;
    assign ctrl.ALUSrcA    = alu_src_a_s;
    assign ctrl.ALUSrcB    = alu_src_b_s;
    assign ctrl.PCSrc      = pc_src_s;
    assign ctrl.IorD       = iord_s;
    assign ctrl.RegDst     = reg_dst_s;
    assign ctrl.MemtoReg   = mem_to_reg_s;
    assign ctrl.IRWrite    = ir_write_s  & ~reset;
    assign ctrl.MemWrite   = mem_write_s & ~reset;
    assign ctrl.RegWrite   = reg_write_s & ~reset;
    assign ctrl.PCEn       = (pc_write_s | (branch_s & ctrl.Zero)) & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: random instruction stream checked every
// cycle against a phase-list model of each instruction, plus literal checks.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus.master)
    );

    typedef struct packed {
        logic [2:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       irw;
        logic       memw;
        logic       regw;
        logic       regdst;
        logic       memtoreg;
        logic       pcwrite;
        logic       branch;
    } exp_t;

    localparam int P_FETCH = 0, P_DECODE = 1, P_ADDR = 2, P_MEMRD = 3, P_MEMWB = 4,
                   P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_ADDIWB = 9,
                   P_JUMP = 10;

    int         n_checks = 0;
    int         n_fail = 0;
    exp_t       q[$];
    int         cyc_idx;
    logic [5:0] cur_op;
    logic [5:0] cur_funct;
    logic       skip_fetch = 1'b0;

    // Reference ALU operation for an R-type funct field.
    function automatic logic [2:0] funct_ref(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            6'b000111: return 3'b101;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs of one instruction phase, starting from all-off / add.
    function automatic exp_t phase(input int p, input logic [5:0] f);
        exp_t e;
        e = '0;
        e.alu = 3'b010;
        case (p)
            P_FETCH:  begin e.srcb = 2'b01; e.irw = 1'b1; e.pcwrite = 1'b1; end
            P_DECODE: e.srcb = 2'b11;
            P_ADDR:   begin e.srca = 1'b1; e.srcb = 2'b10; end
            P_MEMRD:  e.iord = 1'b1;
            P_MEMWB:  begin e.memtoreg = 1'b1; e.regw = 1'b1; end
            P_MEMWR:  begin e.iord = 1'b1; e.memw = 1'b1; end
            P_EXEC:   begin e.srca = 1'b1; e.alu = funct_ref(f); end
            P_ALUWB:  begin e.regdst = 1'b1; e.regw = 1'b1; end
            P_BRANCH: begin e.srca = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01; e.branch = 1'b1; end
            P_ADDIWB: e.regw = 1'b1;
            P_JUMP:   begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
            default:  e.alu = 3'b010;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s op=%b idx=%0d act=%h exp=%h t=%0t", name, cur_op, cyc_idx, act, exp, $time);
        end
    endtask

    // Queue the phase list of one instruction and pin its length independently.
    task automatic build(input logic [5:0] op, input logic [5:0] f);
        int lat;
        q.delete();
        q.push_back(phase(P_FETCH, f));
        q.push_back(phase(P_DECODE, f));
        case (op)
            6'b100011: begin q.push_back(phase(P_ADDR, f)); q.push_back(phase(P_MEMRD, f)); q.push_back(phase(P_MEMWB, f)); end
            6'b101011: begin q.push_back(phase(P_ADDR, f)); q.push_back(phase(P_MEMWR, f)); end
            6'b000000: begin q.push_back(phase(P_EXEC, f)); q.push_back(phase(P_ALUWB, f)); end
            6'b000100: q.push_back(phase(P_BRANCH, f));
            6'b001000: begin q.push_back(phase(P_ADDR, f)); q.push_back(phase(P_ADDIWB, f)); end
            6'b000010: q.push_back(phase(P_JUMP, f));
            default: ;
        endcase
        if (op == 6'b100011) lat = 5;
        else if (op == 6'b101011 || op == 6'b000000 || op == 6'b001000) lat = 4;
        else if (op == 6'b000100 || op == 6'b000010) lat = 3;
        else lat = 2;
        check("latency", q.size(), lat);
    endtask

    function automatic logic [14:0] exp_vec(input exp_t e, input logic z);
        return {e.alu, e.srca, e.srcb, e.pcsrc, e.iord, e.irw, e.memw, e.regw,
                e.regdst, e.memtoreg, e.pcwrite | (e.branch & z)};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {bus.AluControl, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.IorD, bus.IRWrite,
                bus.MemWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.PCEn};
    endfunction

    // Per-cycle comparison against the model plus literal spot checks.
    task automatic compare_cycle(input exp_t e);
        check("outputs", dut_vec(), exp_vec(e, bus.Zero));
        if (cur_op == 6'b100011)
            check("lw_regwrite_only_c5", bus.RegWrite, (cyc_idx == 4) ? 1 : 0);
        if (cur_op == 6'b101011 && cyc_idx == 3)
            check("sw_memwrite_c4", bus.MemWrite, 1);
        if (cur_op == 6'b000010 && cyc_idx == 2)
            check("j_pcsrc_pcen_c3", {bus.PCSrc, bus.PCEn}, 3'b101);
        if (cur_op == 6'b001000 && cyc_idx == 3)
            check("addi_wb_c4", {bus.RegWrite, bus.RegDst}, 2'b10);
        if (cur_op == 6'b000000 && cur_funct == 6'b000111 && cyc_idx == 2)
            check("srav_exec", {bus.AluControl, bus.ALUSrcA}, 4'b1011);
        if (cur_op == 6'b000000 && cyc_idx == 3)
            check("rtype_wb", {bus.RegDst, bus.RegWrite}, 2'b11);
        if (cur_op == 6'b000100 && cyc_idx == 2)
            check("beq_pcen", {bus.PCEn, bus.PCSrc}, {bus.Zero, 2'b01});
        if (cur_op == 6'b111111 && cyc_idx == 1)
            check("illegal_decode_quiet", {bus.MemWrite, bus.RegWrite, bus.PCEn}, 3'b000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, {bus.IRWrite, bus.PCEn, bus.MemWrite, bus.RegWrite}, 4'b0000);
        check({tag, "_selects"}, {bus.AluControl, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.IorD,
                                  bus.RegDst, bus.MemtoReg}, {3'b010, 1'b0, 2'b01, 2'b00, 3'b000});
    endtask

    logic [5:0] dir_op [10] = '{6'b100011, 6'b000000, 6'b000100, 6'b000100, 6'b111111,
                                6'b101011, 6'b101011, 6'b000010, 6'b001000, 6'b000000};
    logic [5:0] dir_fn [10] = '{6'b000000, 6'b000111, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b100010};
    int         dir_z  [10] = '{2, 2, 1, 0, 1, 2, 2, 2, 2, 2};
    int         dir_p  [10] = '{-1, -1, -1, -1, -1, 3, -1, -1, -1, -1};

    logic [5:0] op_pool [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                6'b001000, 6'b000010, 6'b111111};
    logic [5:0] fn_pool [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b101010, 6'b000111};

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   zmode;
        int   pulse_idx;
        bus.Op = 6'b000000;
        bus.Funct = 6'b000000;
        bus.Zero = 1'b1;
        cur_op = 6'b000000;
        cur_funct = 6'b000000;
        cyc_idx = 0;
        #5;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_clocked");
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 170; k++) begin
            if (k < 10) begin
                cur_op = dir_op[k]; cur_funct = dir_fn[k];
                zmode = dir_z[k]; pulse_idx = dir_p[k];
            end else begin
                cur_op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 6)];
                cur_funct = ($urandom_range(0, 1) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 5)];
                zmode = 2;
                pulse_idx = ($urandom_range(0, 11) == 0) ? 32'($urandom_range(0, 4)) : -1;
            end
            bus.Op = cur_op;
            bus.Funct = cur_funct;
            build(cur_op, cur_funct);
            cyc_idx = 0;
            if (skip_fetch) begin
                e = q.pop_front();
                #1 compare_cycle(e);
                skip_fetch = 1'b0;
                @(negedge clk);
                cyc_idx = 1;
            end
            while (q.size() > 0) begin
                e = q.pop_front();
                bus.Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
                #1 compare_cycle(e);
                if (cyc_idx == pulse_idx) begin
                    #1 reset = 1'b1;
                    #1 check_reset_outputs("midreset");
                    #1 reset = 1'b0;
                    q.delete();
                    skip_fetch = 1'b1;
                end else begin
                    @(negedge clk);
                    cyc_idx++;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the 32-bit multicycle MIPS datapath.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Op  input  6  instruction[31:26], valid from the instruction register.
REQ-005 Funct  input  6  instruction[5:0].
REQ-006 Zero  input  1  ALU zero flag, combinational from the ALU in the same cycle.
REQ-007 AluControl  output  3  ALU operation: 000 and, 001 or, 010 add, 110 sub, 111 slt, 101 srav (rt >>> rs).
REQ-008 ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-009 ALUSrcB  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
REQ-010 PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-011 IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg  output  1 each  standard multicycle datapath strobes and selects.
REQ-012 PCEn  output  1  PC load enable, equal to PCWrite OR (Branch AND Zero).

Function
REQ-013 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB and JUMP, and its outputs SHALL depend on the state only, except PCEn (state and Zero) and AluControl (state and Funct).
REQ-014 FETCH SHALL drive IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00, IRWrite=1 and PCWrite=1, then go to DECODE.
REQ-015 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and add (branch target into ALUOut), then branch on Op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXECUTE
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEXEC
- 000010 (j) -> JUMP
- any other Op -> FETCH, with no write strobes asserted.
REQ-016 MEMADR and ADDIEXEC SHALL drive ALUSrcA=1, ALUSrcB=10 and add; MEMADR then goes to MEMRD for lw or MEMWR for sw, and ADDIEXEC goes to ADDIWB.
REQ-017 Memory states:
- MEMRD SHALL drive IorD=1 and go to MEMWB.
- MEMWB SHALL drive RegDst=0, MemtoReg=1 and RegWrite=1.
- MEMWR SHALL drive IorD=1 and MemWrite=1.
- MEMWB and MEMWR SHALL then go to FETCH.
REQ-018 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00 and AluControl decoded from Funct, then go to ALUWB:
- 100000 -> 010
- 100010 -> 110
- 100100 -> 000
- 100101 -> 001
- 101010 -> 111
- 000111 -> 101
- any other Funct -> 010
REQ-019 ALUWB SHALL drive RegDst=1, MemtoReg=0 and RegWrite=1; ADDIWB SHALL drive RegDst=0, MemtoReg=0 and RegWrite=1; both then go to FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01 and Branch=1, so PCEn equals Zero in the same cycle, then go to FETCH.
REQ-021 JUMP SHALL drive PCSrc=10 and PCWrite=1, then go to FETCH.
REQ-022 Any strobe not listed for a state SHALL be 0, and any select not listed SHALL be 0 (AluControl defaults to 010).
REQ-023 Instruction latencies SHALL be:
- lw 5 cycles
- sw, R-type and addi 4 cycles
- beq and j 3 cycles
- illegal Op 2 cycles
REQ-024 An unreachable state encoding SHALL return to FETCH on the next edge.

Reset
REQ-025 Asserting reset SHALL force the state to FETCH asynchronously, with no clock edge required.
REQ-026 While reset is high, IRWrite, PCEn, MemWrite and RegWrite SHALL be 0; the remaining outputs SHALL show FETCH values.
REQ-027 Reset asserted mid-instruction SHALL abandon that instruction with no further writes, and the first edge after release SHALL execute FETCH.

Structure
REQ-028 A shared package mips_pkg SHALL hold:
- the state enum
- the Op and Funct localparams
- the ALU operation codes of REQ-007
- the 2-bit ALUOp encoding: 00 add, 01 sub, 10 funct
REQ-029 A combinational sub-module alu_decoder (ALUOp, Funct -> AluControl) SHALL be instantiated once; the FSM drives ALUOp.

Verification
REQ-030 Reset low, Op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 only in cycle 5.
REQ-031 Op=000000, Funct=000111 -> AluControl=101 and ALUSrcA=1 in EXECUTE; RegDst=1 and RegWrite=1 in ALUWB.
REQ-032 Op=000100 with Zero=1 in BRANCH -> PCEn=1 and PCSrc=01; with Zero=0 -> PCEn=0; next state FETCH in both cases.
REQ-033 Op=111111 -> DECODE then FETCH, with MemWrite, RegWrite and PCEn all 0 in DECODE.
REQ-034 Reset pulsed mid-cycle while in MEMWR -> state FETCH and MemWrite=0 immediately, before any clock edge.
REQ-035 Op=101011, Op=000010 and Op=001000 -> MemWrite=1 in cycle 4; PCSrc=10 with PCEn=1 in cycle 3; RegWrite=1 with RegDst=0 in cycle 4, respectively.
